dcache_req_tracker: RTL and testbench
=====================================

// Module: dcache_req_tracker
// PURPOSE
// - Parametrised per-tag transaction tracker between mem_unit and HPDC request/response ports.
// - Blocks reuse of an in-flight tag, caps outstanding requests, and drops responses of killed requests.
// - Runs a drain FSM for fences/ordering: stalls new traffic until every outstanding response has returned.
// PARAMETERS
// - TID_WIDTH     7   tag width; table depth NUM_TAGS = 2**TID_WIDTH
// - MAX_INFLIGHT  16  max accepted-but-unanswered requests, 1..NUM_TAGS
// - CNT_WIDTH     $clog2(MAX_INFLIGHT+1)  in-flight counter width (derived localparam)
// PORTS
// - clk_i           in   1          clock, all state on rising edge
// - rst_i           in   1          asynchronous reset, active high
// - req_valid_i     in   1          core presents a dcache request
// - req_tid_i       in   TID_WIDTH  tag of presented request (= rd)
// - req_ready_o     out  1          request accepted this cycle if req_valid_i
// - dc_req_valid_o  out  1          request valid towards HPDC
// - dc_req_ready_i  in   1          HPDC ready
// - rsp_valid_i     in   1          HPDC response valid
// - rsp_tid_i       in   TID_WIDTH  tag of HPDC response
// - rsp_valid_o     out  1          response forwarded to core (not killed)
// - kill_i          in   1          kill request with tag kill_tid_i
// - kill_tid_i      in   TID_WIDTH  tag to kill
// - drain_i         in   1          level: request drain of all in-flight transactions
// - drain_done_o    out  1          drain complete (combinational, see FSM)
// - inflight_o      out  CNT_WIDTH  current outstanding count
// - protocol_err_o  out  1          sticky protocol violation flag (optional feature)
// BEHAVIOUR
// - Reset: all tags IDLE, inflight_o=0, FSM RUN, protocol_err_o=0; all outputs low except req_ready_o follows dc_req_ready_i.
// - block = (tag[req_tid_i]!=IDLE) | (inflight_o==MAX_INFLIGHT) | (FSM==DRAIN).
// - dc_req_valid_o = req_valid_i & ~block; req_ready_o = dc_req_ready_i & ~block (zero latency, no buffering).
// - send = dc_req_valid_o & dc_req_ready_i: tag[req_tid_i] <= PENDING next cycle.
// - Tag states: IDLE, PENDING, KILLED. PENDING + kill_i on that tag -> KILLED. kill_i on IDLE/KILLED tag: no effect.
// - Response: rsp_valid_o = rsp_valid_i & (tag[rsp_tid_i]==PENDING) & ~(kill_i & kill_tid_i==rsp_tid_i).
//   PENDING or KILLED tag -> IDLE next cycle; KILLED response is swallowed (rsp_valid_o=0).
// - Same-cycle kill + response on same tag: response dropped, tag -> IDLE.
// - Same-cycle send on tag A + response on tag A: impossible (A blocked while PENDING); response frees A, reuse from next cycle.
// - Same-cycle send tag A + kill tag A: kill ignored (tag IDLE at kill sample); A becomes PENDING.
// - Counter: inflight <= inflight + send - valid_rsp, valid_rsp = rsp_valid_i & tag[rsp_tid_i]!=IDLE.
//   Counts killed transactions until their response returns; never wraps: a response on IDLE tag does not decrement.
// - Full: at inflight==MAX_INFLIGHT no send; a response in that cycle frees one slot from next cycle.
// - FSM RUN->DRAIN when drain_i=1. DRAIN: no sends. DRAIN->RUN when drain_i=0.
//   drain_done_o = (FSM==DRAIN) & (inflight_o==0); held while drain_i stays high.
// - drain_i asserted with inflight 0: DRAIN next cycle, drain_done_o=1 that cycle.
// - Reset mid-operation: all in-flight tags forgotten; later stale responses hit IDLE tags (dropped, err if enabled).
// CONFIGURATION
// - DCACHE_TRACKER_CHECK_EN defined: protocol_err_o sets (sticky until reset) on response to IDLE tag
//   or send with tag not IDLE (bypass of ready); also $error under simulation.
// - Not defined: no check logic, protocol_err_o tied 0; IDLE-tag responses silently dropped.
// TESTING
// - send tid 0x05, rsp tid 0x05 3 cycles later -> rsp_valid_o=1, inflight 0->1->0, tag 0x05 reusable next cycle.
// - send tid 0x05, present tid 0x05 again before rsp -> req_ready_o=0, dc_req_valid_o=0 until cycle after rsp.
// - send tid 0x10, kill_i tid 0x10, rsp tid 0x10 -> rsp_valid_o=0, inflight returns 0, tag IDLE.
// - MAX_INFLIGHT=4: send tids 1..4, present tid 5 -> blocked; rsp tid 2 -> tid 5 accepted next cycle.
// - inflight=3, drain_i=1 -> no sends, drain_done_o=0 until 3 rsps, then 1; drain_i=0 -> RUN, sends resume.
// - CHECK_EN: rsp tid 0x7F on IDLE tag -> protocol_err_o=1 sticky, inflight unchanged; without macro err=0.

Source files
------------

// File: rtl/dcache_req_tracker.sv
// Per-tag tracker between mem_unit and the HPDC request/response ports with a drain FSM.
// Optional sticky protocol checking is enabled by defining DCACHE_TRACKER_CHECK_EN.
module dcache_req_tracker #(
  parameter  int unsigned TID_WIDTH    = 7,
  parameter  int unsigned MAX_INFLIGHT = 16,
  localparam int unsigned CNT_WIDTH    = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [TID_WIDTH-1:0] req_tid_i,
  output logic                 req_ready_o,
  output logic                 dc_req_valid_o,
  input  logic                 dc_req_ready_i,
  input  logic                 rsp_valid_i,
  input  logic [TID_WIDTH-1:0] rsp_tid_i,
  output logic                 rsp_valid_o,
  input  logic                 kill_i,
  input  logic [TID_WIDTH-1:0] kill_tid_i,
  input  logic                 drain_i,
  output logic                 drain_done_o,
  output logic [CNT_WIDTH-1:0] inflight_o,
  output logic                 protocol_err_o
);

  localparam int unsigned NUM_TAGS = 2 ** TID_WIDTH;

  typedef enum logic [1:0] {TAG_IDLE, TAG_PENDING, TAG_KILLED} tag_state_e;
  typedef enum logic {ST_RUN, ST_DRAIN} fsm_state_e;

  tag_state_e           tag_q [NUM_TAGS];
  fsm_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] inflight_q;
  logic                 in_drain;
  logic                 full;
  logic                 block;
  logic                 send;
  logic                 rsp_known;
  logic                 kill_on_rsp;

  assign full        = (inflight_q == CNT_WIDTH'(MAX_INFLIGHT));
  assign block       = (tag_q[req_tid_i] != TAG_IDLE) | full | in_drain;
  assign send        = req_valid_i & ~block & dc_req_ready_i;
  assign rsp_known   = rsp_valid_i & (tag_q[rsp_tid_i] != TAG_IDLE);
  assign kill_on_rsp = kill_i & (kill_tid_i == rsp_tid_i);

  assign dc_req_valid_o = req_valid_i & ~block;
  assign req_ready_o    = dc_req_ready_i & ~block;
  assign rsp_valid_o    = rsp_valid_i & (tag_q[rsp_tid_i] == TAG_PENDING) & ~kill_on_rsp;
  assign inflight_o     = inflight_q;

  // Later assignments take priority: a returning response overrides a same-cycle kill,
  // and a send can only target an IDLE tag, so it never collides with either.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) tag_q[i] <= TAG_IDLE;
    end else begin
      if (kill_i && tag_q[kill_tid_i] == TAG_PENDING) tag_q[kill_tid_i] <= TAG_KILLED;
      if (rsp_known) tag_q[rsp_tid_i] <= TAG_IDLE;
      if (send)      tag_q[req_tid_i] <= TAG_PENDING;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inflight_q <= '0;
    else       inflight_q <= inflight_q + CNT_WIDTH'(send) - CNT_WIDTH'(rsp_known);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain_i)  state_d = ST_DRAIN;
      ST_DRAIN: if (!drain_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    in_drain     = (state_q == ST_DRAIN);
    drain_done_o = in_drain & (inflight_q == '0);
  end

`ifdef DCACHE_TRACKER_CHECK_EN
  logic err_q;
  logic err_event;

  // The busy-tag send term can only fire if the ready gating is ever bypassed.
  assign err_event = (rsp_valid_i & (tag_q[rsp_tid_i] == TAG_IDLE))
                   | (send & (tag_q[req_tid_i] != TAG_IDLE));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          err_q <= 1'b0;
    else if (err_event) err_q <= 1'b1;
  end

  assign protocol_err_o = err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && err_event) $error("dcache_req_tracker: protocol violation");
  end
`endif
`else
  assign protocol_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_req_tracker.sv
// Self-checking bench for dcache_req_tracker: directed scenarios then random traffic
// against a set-based reference model of outstanding/killed tags.
module tb_dcache_req_tracker;
  localparam int TW = 7;
  localparam int MI = 4;
  localparam int CW = $clog2(MI + 1);
  localparam int NT = 2 ** TW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic [TW-1:0] req_tid_i = '0;
  logic          req_ready_o;
  logic          dc_req_valid_o;
  logic          dc_req_ready_i = 1'b1;
  logic          rsp_valid_i = 1'b0;
  logic [TW-1:0] rsp_tid_i = '0;
  logic          rsp_valid_o;
  logic          kill_i = 1'b0;
  logic [TW-1:0] kill_tid_i = '0;
  logic          drain_i = 1'b0;
  logic          drain_done_o;
  logic [CW-1:0] inflight_o;
  logic          protocol_err_o;

  always #5 clk = ~clk;

  dcache_req_tracker #(.TID_WIDTH(TW), .MAX_INFLIGHT(MI)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_tid_i(req_tid_i), .req_ready_o(req_ready_o),
    .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_tid_i(rsp_tid_i), .rsp_valid_o(rsp_valid_o),
    .kill_i(kill_i), .kill_tid_i(kill_tid_i),
    .drain_i(drain_i), .drain_done_o(drain_done_o),
    .inflight_o(inflight_o), .protocol_err_o(protocol_err_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: which tags are awaiting a response, and which of those were killed.
  bit m_out  [NT];
  bit m_kill [NT];
  bit m_drain;
  bit m_err;

  logic          s_ready, s_dcv, s_rsp, s_done, s_err;
  logic [CW-1:0] s_inf;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NT; i++) n += int'(m_out[i]);
    return n;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NT; i++) begin
      m_out[i]  = 1'b0;
      m_kill[i] = 1'b0;
    end
    m_drain = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rv, input int tid, input bit dcr, input bit sv, input int stid,
                      input bit k, input int ktid, input bit dr);
    bit blk, e_dcv, e_ready, e_rsp, hit, snd;
    int cnt;
    @(negedge clk);
    req_valid_i = rv;  req_tid_i = TW'(tid); dc_req_ready_i = dcr;
    rsp_valid_i = sv;  rsp_tid_i = TW'(stid);
    kill_i = k;        kill_tid_i = TW'(ktid);
    drain_i = dr;
    #1;
    cnt     = m_count();
    blk     = m_out[tid] || (cnt == MI) || m_drain;
    e_dcv   = rv && !blk;
    e_ready = dcr && !blk;
    hit     = sv && m_out[stid];
    e_rsp   = hit && !m_kill[stid] && !(k && ktid == stid);
    s_ready = req_ready_o; s_dcv = dc_req_valid_o; s_rsp = rsp_valid_o;
    s_done  = drain_done_o; s_inf = inflight_o; s_err = protocol_err_o;
    chk("req_ready", 32'(s_ready), 32'(e_ready));
    chk("dc_req_valid", 32'(s_dcv), 32'(e_dcv));
    chk("rsp_valid", 32'(s_rsp), 32'(e_rsp));
    chk("inflight", 32'(s_inf), 32'(cnt));
    chk("drain_done", 32'(s_done), 32'(m_drain && cnt == 0));
    chk("protocol_err", 32'(s_err), 32'(m_err));
    snd = e_dcv && dcr;
`ifdef DCACHE_TRACKER_CHECK_EN
    if (sv && !m_out[stid]) m_err = 1'b1;
`endif
    if (k && m_out[ktid]) m_kill[ktid] = 1'b1;
    if (hit) begin m_out[stid] = 1'b0; m_kill[stid] = 1'b0; end
    if (snd) begin m_out[tid] = 1'b1; m_kill[tid] = 1'b0; end
    m_drain = dr;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit dr);
    repeat (n) step(0, 0, 1, 0, 0, 0, 0, dr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    req_valid_i = 1'b0; dc_req_ready_i = 1'b1; rsp_valid_i = 1'b0; kill_i = 1'b0; drain_i = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_dc_req_valid", 32'(dc_req_valid_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_drain_done", 32'(drain_done_o), 32'd0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err_o), 32'd0);
    m_clear();
    @(posedge clk);
    #2 rst_i = 1'b0;
  endtask

  initial begin
    bit dr_r;
    do_reset();

    // Basic send / response / reuse on tag 0x05
    step(1, 5, 1, 0, 0, 0, 0, 0);  chk("t1_send_ready", 32'(s_ready), 32'd1);
    idle(2, 0);                    chk("t1_inflight_mid", 32'(s_inf), 32'd1);
    step(0, 0, 1, 1, 5, 0, 0, 0);  chk("t1_rsp", 32'(s_rsp), 32'd1);
    step(1, 5, 1, 0, 0, 0, 0, 0);  chk("t1_reuse", 32'(s_ready), 32'd1);
                                   chk("t1_inflight_after", 32'(s_inf), 32'd0);
    // In-flight tag blocked until the cycle after its response
    step(1, 5, 1, 0, 0, 0, 0, 0);  chk("t2_blocked", 32'(s_dcv), 32'd0);
    step(1, 5, 1, 1, 5, 0, 0, 0);  chk("t2_rsp_cycle_blocked", 32'(s_ready), 32'd0);
    step(1, 5, 1, 0, 0, 0, 0, 0);  chk("t2_accept", 32'(s_dcv), 32'd1);
    step(0, 0, 1, 1, 5, 0, 0, 0);
    // Killed response swallowed
    step(1, 16, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 16, 0);
    step(0, 0, 1, 1, 16, 0, 0, 0); chk("t3_killed_drop", 32'(s_rsp), 32'd0);
    idle(1, 0);                    chk("t3_inflight", 32'(s_inf), 32'd0);
    // Same-cycle kill + response, same-cycle send + kill
    step(1, 32, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32, 1, 32, 0); chk("kill_rsp_same", 32'(s_rsp), 32'd0);
    step(1, 33, 1, 0, 0, 1, 33, 0);
    step(0, 0, 1, 1, 33, 0, 0, 0);  chk("send_kill_same", 32'(s_rsp), 32'd1);
    // Full at MAX_INFLIGHT
    for (int t = 1; t <= 4; t++) step(1, t, 1, 0, 0, 0, 0, 0);
    step(1, 5, 1, 0, 0, 0, 0, 0);  chk("t4_full_blocked", 32'(s_ready), 32'd0);
                                   chk("t4_full_count", 32'(s_inf), 32'd4);
    step(1, 5, 1, 1, 2, 0, 0, 0);  chk("t4_full_rsp_cycle", 32'(s_dcv), 32'd0);
    step(1, 5, 1, 0, 0, 0, 0, 0);  chk("t4_accept", 32'(s_dcv), 32'd1);
    step(0, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 3, 0, 0, 0);
    step(0, 0, 1, 1, 4, 0, 0, 0);
    step(0, 0, 1, 1, 5, 0, 0, 0);
    // Drain with three outstanding
    for (int t = 7; t <= 9; t++) step(1, t, 1, 0, 0, 0, 0, 0);
    idle(1, 1);
    step(1, 10, 1, 0, 0, 0, 0, 1); chk("t5_drain_blocked", 32'(s_dcv), 32'd0);
    step(1, 10, 1, 1, 7, 0, 0, 1);
    step(1, 10, 1, 1, 8, 0, 0, 1); chk("t5_not_done", 32'(s_done), 32'd0);
    step(1, 10, 1, 1, 9, 0, 0, 1);
    idle(1, 1);                    chk("t5_done", 32'(s_done), 32'd1);
    step(1, 10, 1, 0, 0, 0, 0, 0);
    step(1, 10, 1, 0, 0, 0, 0, 0); chk("t5_resume", 32'(s_dcv), 32'd1);
    step(0, 0, 1, 1, 10, 0, 0, 0);
    // Response on an IDLE tag
    step(0, 0, 1, 1, 127, 0, 0, 0);
    idle(1, 0);                    chk("t6_inflight", 32'(s_inf), 32'd0);
`ifdef DCACHE_TRACKER_CHECK_EN
    chk("t6_err", 32'(s_err), 32'd1);
`else
    chk("t6_err", 32'(s_err), 32'd0);
`endif
    // Reset mid-operation: stale response must be dropped
    step(1, 20, 1, 0, 0, 0, 0, 0);
    step(1, 21, 1, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 1, 1, 20, 0, 0, 0); chk("stale_rsp_drop", 32'(s_rsp), 32'd0);

    // Random traffic over a small tag range to force collisions
    dr_r = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 5) dr_r = ~dr_r;
      step($urandom_range(0, 99) < 70, int'($urandom_range(0, 7)), $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 40, int'($urandom_range(0, 7)),
           $urandom_range(0, 99) < 15, int'($urandom_range(0, 7)), dr_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
